motors_ctrl: RTL and testbench

Responder end of the motors control handshake: accepts a move request (signed X/Y pulse counts plus servo position) from an opcode handler, positions the pen servo, then emits step/direction pulse trains for both stepper axes concurrently. It signals `rdy` when idle and `done` when the move is complete. It sits between the processor's opcode handlers and the physical stepper/servo drivers.

---
 rtl/motors_ctrl.sv | 137 +++++++++++++
 tb/tb_motors_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motors_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motors_ctrl
// Brief    : Accepts a move request, positions the pen servo, then drives
//            concurrent step/direction pulse trains on the X and Y axes.
// Revision : 1.0 - initial release
// ============================================================================
module motors_ctrl #(
  parameter int PULSE_NUM_X_BITS   = 16,
  parameter int PULSE_NUM_Y_BITS   = 16,
  parameter int PULSE_PERIOD_TICKS = 8,
  parameter int PULSE_HIGH_TICKS   = 2,
  parameter int SERVO_SETTLE_TICKS = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        trigger,
  input  logic [PULSE_NUM_X_BITS-1:0] pulse_num_x,
  input  logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
  input  logic                        servo_pos,
  output logic                        rdy,
  output logic                        done,
  output logic                        step_x,
  output logic                        step_y,
  output logic                        dir_x,
  output logic                        dir_y,
  output logic                        servo_out
);

  localparam int c_CNT_W = $clog2(PULSE_PERIOD_TICKS);
  localparam int c_SET_W = $clog2(SERVO_SETTLE_TICKS + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PULSE_PERIOD_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HIGH = c_CNT_W'(PULSE_HIGH_TICKS);
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SERVO_SETTLE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVO_WAIT = 2'd1,
    ST_STEP       = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [PULSE_NUM_X_BITS-1:0] r_rem_x, w_rem_x_nxt, w_abs_x, w_rem_x_dec;
  logic [PULSE_NUM_Y_BITS-1:0] r_rem_y, w_rem_y_nxt, w_abs_y, w_rem_y_dec;
  logic [c_CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [c_SET_W-1:0]          r_settle, w_settle_nxt;
  logic                        w_dir_x_nxt, w_dir_y_nxt, w_servo_nxt;

  // Magnitude kept at full width so the most negative count is representable
  assign w_abs_x = pulse_num_x[PULSE_NUM_X_BITS-1] ? ((~pulse_num_x) + PULSE_NUM_X_BITS'(1)) : pulse_num_x;
  assign w_abs_y = pulse_num_y[PULSE_NUM_Y_BITS-1] ? ((~pulse_num_y) + PULSE_NUM_Y_BITS'(1)) : pulse_num_y;

  assign w_rem_x_dec = (r_rem_x != '0) ? (r_rem_x - PULSE_NUM_X_BITS'(1)) : '0;
  assign w_rem_y_dec = (r_rem_y != '0) ? (r_rem_y - PULSE_NUM_Y_BITS'(1)) : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_x_nxt  = r_rem_x;
    w_rem_y_nxt  = r_rem_y;
    w_cnt_nxt    = r_cnt;
    w_settle_nxt = r_settle;
    w_dir_x_nxt  = dir_x;
    w_dir_y_nxt  = dir_y;
    w_servo_nxt  = servo_out;
    case (r_state)
      ST_IDLE: begin
        if (trigger) begin
          w_rem_x_nxt  = w_abs_x;
          w_rem_y_nxt  = w_abs_y;
          w_dir_x_nxt  = pulse_num_x[PULSE_NUM_X_BITS-1];
          w_dir_y_nxt  = pulse_num_y[PULSE_NUM_Y_BITS-1];
          w_servo_nxt  = servo_pos;
          w_cnt_nxt    = '0;
          w_settle_nxt = '0;
          if (servo_pos != servo_out)
            w_state_nxt = ST_SERVO_WAIT;
          else if ((w_abs_x != '0) || (w_abs_y != '0))
            w_state_nxt = ST_STEP;
          else
            w_state_nxt = ST_DONE;
        end
      end
      ST_SERVO_WAIT: begin
        if (r_settle == c_SET_LAST) begin
          w_settle_nxt = '0;
          w_state_nxt  = ((r_rem_x != '0) || (r_rem_y != '0)) ? ST_STEP : ST_DONE;
        end else begin
          w_settle_nxt = r_settle + c_SET_W'(1);
        end
      end
      ST_STEP: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_rem_x_nxt = w_rem_x_dec;
          w_rem_y_nxt = w_rem_y_dec;
          if ((w_rem_x_dec == '0) && (w_rem_y_dec == '0))
            w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rem_x   <= '0;
      r_rem_y   <= '0;
      r_cnt     <= '0;
      r_settle  <= '0;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      servo_out <= 1'b0;
    end else if (clk_en) begin
      r_state   <= w_state_nxt;
      r_rem_x   <= w_rem_x_nxt;
      r_rem_y   <= w_rem_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_settle  <= w_settle_nxt;
      dir_x     <= w_dir_x_nxt;
      dir_y     <= w_dir_y_nxt;
      servo_out <= w_servo_nxt;
    end
  end

  assign rdy    = (r_state == ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign step_x = (r_state == ST_STEP) && (r_rem_x != '0) && (r_cnt < c_CNT_HIGH);
  assign step_y = (r_state == ST_STEP) && (r_rem_y != '0) && (r_cnt < c_CNT_HIGH);

endmodule
`default_nettype wire

// File: tb/tb_motors_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_motors_ctrl
// Brief    : Scoreboard bench for motors_ctrl; moves are queued as expected
//            records and a monitor checks each completed move.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motors_ctrl;

  typedef struct {
    int   lat;
    int   px;
    int   py;
    int   hx;
    int   hy;
    logic dx;
    logic dy;
    logic sv;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset;
  logic        trig_a, trig_b, spos;
  logic [15:0] x_a, y_a;
  logic [7:0]  x_b, y_b;
  logic        rdy_a, done_a, sx_a, sy_a, dx_a, dy_a, sv_a;
  logic        rdy_b, done_b, sx_b, sy_b, dx_b, dy_b, sv_b;

  exp_t q0[$];
  exp_t q1[$];
  chk_t chk_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   div = 1;
  int   div_cnt = 0;
  int   rst_edges = 0;

  motors_ctrl dut_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trig_a),
    .pulse_num_x(x_a), .pulse_num_y(y_a), .servo_pos(spos),
    .rdy(rdy_a), .done(done_a), .step_x(sx_a), .step_y(sy_a),
    .dir_x(dx_a), .dir_y(dy_a), .servo_out(sv_a)
  );

  // Narrow instance so the most-negative-count case stays short
  motors_ctrl #(.PULSE_NUM_X_BITS(8), .PULSE_NUM_Y_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trig_b),
    .pulse_num_x(x_b), .pulse_num_y(y_b), .servo_pos(spos),
    .rdy(rdy_b), .done(done_b), .step_x(sx_b), .step_y(sy_b),
    .dir_x(dx_b), .dir_y(dy_b), .servo_out(sv_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div_cnt = (div_cnt + 1) % div;
    clk_en  = (div_cnt == 0);
  end

  always @(posedge reset) rst_edges++;

  task automatic cmp(input string nm, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic push_chk(input string nm, input int a, input int e);
    chk_t c;
    c.name = nm;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  // ---------------- monitor ----------------
  logic [6:0] obs [2];
  assign obs[0] = {rdy_a, done_a, sx_a, sy_a, dx_a, dy_a, sv_a};
  assign obs[1] = {rdy_b, done_b, sx_b, sy_b, dx_b, dy_b, sv_b};

  logic [6:0] prev [2];
  bit   act [2];
  bit   pdone [2];
  int   tc [2], px [2], py [2], hx [2], hy [2];
  int   rst_ack = 0;

  always @(posedge clk) begin : mon
    logic       en;
    logic [6:0] o;
    chk_t       c;
    exp_t       e;
    bit         have;
    en = clk_en;
    #1;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (reset || (rst_ack != rst_edges)) begin
      rst_ack = rst_edges;
      for (int i = 0; i < 2; i++) begin
        act[i]   = 1'b0;
        pdone[i] = 1'b0;
        prev[i]  = obs[i];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        o = obs[i];
        if (!en) begin
          cmp($sformatf("frozen_%0d", i), int'(o), int'(prev[i]));
        end else begin
          cmp($sformatf("rdy_done_excl_%0d", i), int'(o[6] & o[5]), 0);
          if (pdone[i]) cmp($sformatf("rdy_after_done_%0d", i), int'(o[6]), 1);
          pdone[i] = o[5];
          if (!act[i] && !o[6]) begin
            act[i] = 1'b1;
            tc[i] = 0; px[i] = 0; py[i] = 0; hx[i] = 0; hy[i] = 0;
          end
          if (act[i]) begin
            if (o[4]) hx[i]++;
            if (o[3]) hy[i]++;
            if (o[4] && !prev[i][4]) px[i]++;
            if (o[3] && !prev[i][3]) py[i]++;
            if (o[5]) begin
              if (i == 0) begin
                have = (q0.size() != 0);
                if (have) e = q0.pop_front();
              end else begin
                have = (q1.size() != 0);
                if (have) e = q1.pop_front();
              end
              cmp($sformatf("done_was_expected_%0d", i), int'(have), 1);
              if (have) begin
                cmp($sformatf("latency_%0d", i), tc[i], e.lat);
                cmp($sformatf("pulses_x_%0d", i), px[i], e.px);
                cmp($sformatf("pulses_y_%0d", i), py[i], e.py);
                cmp($sformatf("high_ticks_x_%0d", i), hx[i], e.hx);
                cmp($sformatf("high_ticks_y_%0d", i), hy[i], e.hy);
                cmp($sformatf("dir_x_%0d", i), int'(o[2]), int'(e.dx));
                cmp($sformatf("dir_y_%0d", i), int'(o[1]), int'(e.dy));
                cmp($sformatf("servo_%0d", i), int'(o[0]), int'(e.sv));
              end
              act[i] = 1'b0;
            end else begin
              tc[i]++;
            end
          end
        end
        prev[i] = o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_tick;
    @(posedge clk iff clk_en);
    @(negedge clk);
  endtask

  task automatic send(input bit b, input logic [15:0] x, input logic [15:0] y,
                      input logic s, input bit push, input int lat,
                      input int npx, input int npy,
                      input logic edx, input logic edy, input logic esv);
    exp_t e;
    e.lat = lat; e.px = npx; e.py = npy; e.hx = 2 * npx; e.hy = 2 * npy;
    e.dx = edx; e.dy = edy; e.sv = esv;
    if (push) begin
      if (b) q1.push_back(e);
      else   q0.push_back(e);
    end
    spos = s;
    if (!b) begin x_a = x; y_a = y; trig_a = 1'b1; end
    else    begin x_b = x[7:0]; y_b = y[7:0]; trig_b = 1'b1; end
    next_tick;
    trig_a = 1'b0;
    trig_b = 1'b0;
    x_a = 16'h1234; y_a = 16'h8765; x_b = 8'h5A; y_b = 8'hA5;
  endtask

  task automatic wait_idle(input bit b, input int budget);
    int k;
    k = 0;
    while (k < budget && !(b ? (q1.size() == 0 && rdy_b) : (q0.size() == 0 && rdy_a))) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) push_chk("idle_timeout", k, 0);
  endtask

  initial begin
    int k;
    reset = 1'b1; trig_a = 1'b0; trig_b = 1'b0; spos = 1'b0;
    x_a = '0; y_a = '0; x_b = '0; y_b = '0;
    #3;
    push_chk("reset_rdy", int'(rdy_a), 1);
    push_chk("reset_done", int'(done_a), 0);
    push_chk("reset_servo", int'(sv_a), 0);
    push_chk("reset_dirs", int'({dx_a, dy_a}), 0);
    push_chk("reset_steps", int'({sx_a, sy_a}), 0);
    #10 reset = 1'b0;
    @(negedge clk);

    send(0, 16'd3, 16'd1, 1'b0, 1, 24, 3, 1, 1'b0, 1'b0, 1'b0);
    wait_idle(0, 3000);
    send(0, 16'hFFFE, 16'hFFFB, 1'b0, 1, 40, 2, 5, 1'b1, 1'b1, 1'b0);
    wait_idle(0, 3000);
    send(0, 16'd0, 16'd0, 1'b1, 1, 100, 0, 0, 1'b0, 1'b0, 1'b1);
    push_chk("servo_early", int'(sv_a), 1);
    wait_idle(0, 3000);
    send(0, 16'd0, 16'd0, 1'b1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    wait_idle(0, 3000);
    send(0, 16'd1, 16'd0, 1'b0, 1, 108, 1, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(0, 3000);

    // Triggers while busy must be ignored
    send(0, 16'd2, 16'd2, 1'b0, 1, 16, 2, 2, 1'b0, 1'b0, 1'b0);
    repeat (5) next_tick;
    x_a = 16'd9; y_a = 16'd9; spos = 1'b1; trig_a = 1'b1;
    next_tick;
    trig_a = 1'b0;
    k = 0;
    while (!done_a && k < 200) begin @(negedge clk); k++; end
    x_a = 16'd7; y_a = 16'd7; spos = 1'b1; trig_a = 1'b1;
    next_tick;
    trig_a = 1'b0;
    wait_idle(0, 3000);
    repeat (30) next_tick;

    // Abort in the middle of stepping
    send(0, 16'hFFFC, 16'd3, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (105) next_tick;
    #2 reset = 1'b1;
    #1;
    push_chk("abort_rdy", int'(rdy_a), 1);
    push_chk("abort_done", int'(done_a), 0);
    push_chk("abort_steps", int'({sx_a, sy_a}), 0);
    push_chk("abort_dirs", int'({dx_a, dy_a}), 0);
    push_chk("abort_servo", int'(sv_a), 0);
    #1 reset = 1'b0;
    repeat (60) next_tick;
    push_chk("abort_idle", int'(rdy_a), 1);

    // Sparse enable: one tick every third clock
    div = 3;
    repeat (4) @(negedge clk);
    send(0, 16'd3, 16'd1, 1'b0, 1, 24, 3, 1, 1'b0, 1'b0, 1'b0);
    wait_idle(0, 3000);
    div = 1;
    repeat (4) @(negedge clk);

    send(1, 16'hFFFE, 16'hFF80, 1'b0, 1, 1024, 2, 128, 1'b1, 1'b1, 1'b0);
    wait_idle(1, 5000);

    repeat (4) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
